// File: rtl/fmdll_mn_counter.sv
// rtl/fmdll_mn_counter.sv - FMDLL N/M compare-window timing generator.
// Optional COMP_FILTER_EN: majority-of-3 filtering of the per-frame COMP result.
module fmdll_mn_counter #(
  parameter int NW = 4,
  parameter int MW = 2
) (
  input  logic          clk_out,
  input  logic          Reset_n,
  input  logic          en,
  input  logic [NW-1:0] N,
  input  logic [MW-1:0] M,
  input  logic          COMP,
  output logic [MW-1:0] M_counter,
  output logic [NW-1:0] N_counter,
  output logic          DIV_M,
  output logic          comp_valid,
  output logic          comp_sample,
  output logic          cfg_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]    state;
  logic [NW-1:0] n_sh;
  logic [MW-1:0] m_sh;
  logic [MW-1:0] m_load;
  logic          n_wrap;
  logic          frame_end;
  logic          window_end;
  logic          pending;

  assign m_load     = (M == '0) ? MW'(1) : M;
  assign n_wrap     = (N_counter == n_sh);
  assign frame_end  = n_wrap && (M_counter == m_sh);
  assign window_end = (state == ST_RUN) && n_wrap && (M_counter == MW'(1));
  assign DIV_M      = (state == ST_RUN) && (M_counter == '0);
  assign cfg_err    = (state == ST_ARM) && (N == '0);

  always_ff @(posedge clk_out or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      n_sh      <= NW'(1);
      m_sh      <= MW'(1);
      N_counter <= '0;
      M_counter <= '0;
    end else if (!en) begin
      state     <= ST_IDLE;
      N_counter <= '0;
      M_counter <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_ARM;
          N_counter <= '0;
          M_counter <= '0;
        end
        ST_ARM: begin
          n_sh <= N;
          m_sh <= m_load;
          if (N != '0) begin
            state     <= ST_RUN;
            N_counter <= NW'(1);
            M_counter <= '0;
          end
        end
        ST_RUN: begin
          // Shadow lengths only change at a frame boundary, so a frame always completes as started.
          if (frame_end) begin
            n_sh      <= N;
            m_sh      <= m_load;
            M_counter <= '0;
            if (N == '0) begin
              state     <= ST_ARM;
              N_counter <= '0;
            end else begin
              N_counter <= NW'(1);
            end
          end else if (n_wrap) begin
            N_counter <= NW'(1);
            M_counter <= M_counter + MW'(1);
          end else begin
            N_counter <= N_counter + NW'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          N_counter <= '0;
          M_counter <= '0;
        end
      endcase
    end
  end

`ifdef COMP_FILTER_EN
  logic [1:0] hist;
  logic [1:0] frames;
  logic       maj;

  assign maj = (COMP & hist[0]) | (COMP & hist[1]) | (hist[0] & hist[1]);
`endif

  always_ff @(posedge clk_out or negedge Reset_n) begin
    if (!Reset_n) begin
      pending     <= 1'b0;
      comp_valid  <= 1'b0;
      comp_sample <= 1'b0;
`ifdef COMP_FILTER_EN
      hist        <= '0;
      frames      <= '0;
`endif
    end else begin
      pending    <= en && window_end;
      comp_valid <= 1'b0;
`ifdef COMP_FILTER_EN
      // History is only meaningful within one continuous RUN; valid waits for three samples.
      if (!en || state != ST_RUN) begin
        hist   <= '0;
        frames <= '0;
      end else if (pending) begin
        hist <= {hist[0], COMP};
        if (frames == 2'd2) begin
          comp_valid  <= 1'b1;
          comp_sample <= maj;
        end else begin
          frames <= frames + 2'd1;
        end
      end
`else
      if (pending && en) begin
        comp_valid  <= 1'b1;
        comp_sample <= COMP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fmdll_mn_counter.sv
// tb/tb_fmdll_mn_counter.sv - directed self-checking bench for fmdll_mn_counter.
module tb_fmdll_mn_counter;

  logic       clk_out = 1'b0;
  logic       Reset_n;
  logic       en;
  logic [3:0] N;
  logic [1:0] M;
  logic       COMP;
  logic [1:0] M_counter;
  logic [3:0] N_counter;
  logic       DIV_M;
  logic       comp_valid;
  logic       comp_sample;
  logic       cfg_err;

  int n_pass  = 0;
  int n_total = 0;
  int pat[6]  = '{1, 0, 1, 0, 0, 0};
`ifdef COMP_FILTER_EN
  int f_valid[5] = '{0, 0, 1, 1, 1};
  int f_samp[5]  = '{0, 0, 1, 0, 0};
`else
  int f_valid[5] = '{1, 1, 1, 1, 1};
  int f_samp[5]  = '{1, 0, 1, 0, 0};
`endif

  fmdll_mn_counter #(.NW(4), .MW(2)) dut (
    .clk_out     (clk_out),
    .Reset_n     (Reset_n),
    .en          (en),
    .N           (N),
    .M           (M),
    .COMP        (COMP),
    .M_counter   (M_counter),
    .N_counter   (N_counter),
    .DIV_M       (DIV_M),
    .comp_valid  (comp_valid),
    .comp_sample (comp_sample),
    .cfg_err     (cfg_err)
  );

  always #5 clk_out = ~clk_out;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic go_idle();
    en = 1'b0;
    @(negedge clk_out);
    check("idle_n", N_counter, 0);
    check("idle_m", M_counter, 0);
  endtask

  initial begin
    Reset_n = 1'b0; en = 1'b0; N = 4'd0; M = 2'd0; COMP = 1'b0;
    @(negedge clk_out);
    @(negedge clk_out);
    check("rst_n", N_counter, 0);
    check("rst_m", M_counter, 0);
    check("rst_div", DIV_M, 0);
    check("rst_valid", comp_valid, 0);
    check("rst_sample", comp_sample, 0);
    check("rst_cfg", cfg_err, 0);
    Reset_n = 1'b1;
    @(negedge clk_out);

    // Basic count N=3, M=2
    N = 4'd3; M = 2'd2; COMP = 1'b1; en = 1'b1;
    @(negedge clk_out);
    check("t2_arm_n", N_counter, 0);
    check("t2_arm_cfg", cfg_err, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_out);
      check($sformatf("t2_n%0d", i), N_counter, i % 3 + 1);
      check($sformatf("t2_m%0d", i), M_counter, (i / 3) % 3);
      check($sformatf("t2_div%0d", i), DIV_M, int'(((i / 3) % 3) == 0));
      check($sformatf("t2_valid%0d", i), comp_valid, int'(i == 7));
      check($sformatf("t2_samp%0d", i), comp_sample, int'(i >= 7));
    end

    // Handshake N=4, M=1: COMP high only in the cycle after the window end
    go_idle();
    N = 4'd4; M = 2'd1; COMP = 1'b0; en = 1'b1;
    @(negedge clk_out);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_out);
      check($sformatf("t3_n%0d", i), N_counter, i % 4 + 1);
      check($sformatf("t3_m%0d", i), M_counter, (i / 4) % 2);
      check($sformatf("t3_valid%0d", i), comp_valid, int'(i == 9 || i == 17));
      check($sformatf("t3_samp%0d", i), comp_sample, int'(i < 17));
      COMP = (i == 8);
    end

    // Mid-frame reconfig N 4->6, then en drop with a pulse pending
    go_idle();
    N = 4'd4; M = 2'd1; COMP = 1'b1; en = 1'b1;
    @(negedge clk_out);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk_out);
      check($sformatf("t4_n%0d", i), N_counter, (i < 8) ? (i % 4 + 1) : ((i - 8) % 6 + 1));
      check($sformatf("t4_m%0d", i), M_counter, (i < 8) ? (i / 4) : (((i - 8) / 6) % 2));
      check($sformatf("t4_valid%0d", i), comp_valid, int'(i == 9));
      check($sformatf("t4_samp%0d", i), comp_sample, int'(i >= 9));
      if (i == 2) N = 4'd6;
      if (i == 20) begin en = 1'b0; COMP = 1'b0; end
    end
    @(negedge clk_out);
    check("drop_valid", comp_valid, 0);
    check("drop_sample", comp_sample, 1);
    check("drop_n", N_counter, 0);

    // Config error N=0, then recover with N=5 and M=0 (treated as 1)
    N = 4'd0; M = 2'd1; en = 1'b1;
    @(negedge clk_out);
    check("t5_cfg0", cfg_err, 1);
    @(negedge clk_out);
    check("t5_cfg1", cfg_err, 1);
    check("t5_n", N_counter, 0);
    check("t5_m", M_counter, 0);
    N = 4'd5; M = 2'd0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_out);
      check($sformatf("t5_n%0d", i), N_counter, i % 5 + 1);
      check($sformatf("t5_m%0d", i), M_counter, (i / 5) % 2);
      check($sformatf("t5_cfg%0d", i), cfg_err, 0);
    end

    // Per-frame COMP sequence 1,0,1,0,0 with N=1, M=1 (2-cycle frames)
    go_idle();
    N = 4'd1; M = 2'd1; COMP = 1'b0; en = 1'b1;
    @(negedge clk_out);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk_out);
      check($sformatf("t6_n%0d", i), N_counter, 1);
      check($sformatf("t6_m%0d", i), M_counter, i % 2);
      if (i >= 3 && (i % 2) == 1) begin
        check($sformatf("t6_valid%0d", i), comp_valid, f_valid[(i - 3) / 2]);
        if (f_valid[(i - 3) / 2] != 0)
          check($sformatf("t6_samp%0d", i), comp_sample, f_samp[(i - 3) / 2]);
      end else begin
        check($sformatf("t6_valid%0d", i), comp_valid, 0);
      end
      COMP = (i >= 2) ? pat[(i - 2) / 2][0] : 1'b0;
    end

    // Asynchronous reset mid-RUN with N=4, M=2
    go_idle();
    N = 4'd4; M = 2'd2; COMP = 1'b1; en = 1'b1;
    @(negedge clk_out);
    @(negedge clk_out);
    @(negedge clk_out);
    check("t1_pre_n", N_counter, 2);
    check("t1_pre_div", DIV_M, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("t1_n", N_counter, 0);
    check("t1_m", M_counter, 0);
    check("t1_div", DIV_M, 0);
    check("t1_valid", comp_valid, 0);
    check("t1_sample", comp_sample, 0);
    check("t1_cfg", cfg_err, 0);
    en = 1'b0;
    @(negedge clk_out);
    check("t1_hold_n", N_counter, 0);
    Reset_n = 1'b1;
    @(negedge clk_out);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
